// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between CPU writeback and a
// small FIFO of external (game/IO) writes. The CPU normally has priority;
// an external entry that waits too long forces a one-cycle CPU stall so the
// external write can drain. Writes to r0 and r29 are consumed silently.

module rf_write_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                         clock,
   input  logic                         ctrl_reset,
   input  logic                         cpu_we,
   input  logic [4:0]                   cpu_waddr,
   input  logic [31:0]                  cpu_wdata,
   output logic                         cpu_stall,
   input  logic                         ext_req,
   input  logic [4:0]                   ext_addr,
   input  logic [31:0]                  ext_data,
   output logic                         ext_ack,
   output logic                         ctrl_writeEnable,
   output logic [4:0]                   ctrl_writeReg,
   output logic [31:0]                  data_writeReg,
   output logic [$clog2(FIFO_DEPTH):0]  ext_count
);

   // FIFO_DEPTH is a power of two (>= 2), so pointers wrap naturally.
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int WCNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int ENTRY_W = 5 + 32;

   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
   localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(1'b0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1'b1);
   localparam logic [WCNT_W-1:0] WCNT_ZERO = WCNT_W'(1'b0);
   localparam logic [WCNT_W-1:0] WCNT_TRIG = WCNT_W'(STARVE_LIMIT - 1);
   localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // FIFO empty
      ST_WAIT  = 2'd1,   // FIFO holds entries, CPU has priority
      ST_FORCE = 2'd2    // head entry forced through, CPU stalled
   } state_t;

   // r0 is hardwired zero and r29 is fed by the external input path; a
   // write aimed at either is accepted but never reaches the register file.
   function automatic logic is_sink_reg(input logic [4:0] addr);
      is_sink_reg = (addr == 5'd0) || (addr == 5'd29);
   endfunction

   // Saturating increment of the starvation counter.
   function automatic logic [WCNT_W-1:0] wait_inc(input logic [WCNT_W-1:0] cnt);
      if (cnt == WCNT_SAT) begin
         wait_inc = cnt;
      end else begin
         wait_inc = cnt + WCNT_ONE;
      end
   endfunction

   // Registered state
   state_t              state_r;
   logic [WCNT_W-1:0]   wait_cnt_r;
   logic [CNT_W-1:0]    count_r;
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [ENTRY_W-1:0]  mem_r [FIFO_DEPTH];

   // Combinational decode
   logic                full_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic                stall_s;
   logic                sel_valid_s;
   logic [4:0]          sel_addr_s;
   logic [31:0]         sel_data_s;
   logic                write_en_s;
   logic [ENTRY_W-1:0]  head_s;
   logic [4:0]          head_addr_s;
   logic [31:0]         head_data_s;
   logic [CNT_W-1:0]    count_next_s;
   logic [WCNT_W-1:0]   wait_cnt_next_s;
   state_t              state_next_s;

   assign full_s      = (count_r == CNT_FULL);
   assign empty_s     = (count_r == CNT_ZERO);
   assign head_s      = mem_r[rd_ptr_r];
   assign head_addr_s = head_s[ENTRY_W-1:32];
   assign head_data_s = head_s[31:0];

   // Pick the write-port source for this cycle and decide push/pop.
   always_comb begin
      push_s      = 1'b0;
      pop_s       = 1'b0;
      stall_s     = 1'b0;
      sel_valid_s = 1'b0;
      sel_addr_s  = 5'd0;
      sel_data_s  = 32'd0;
      if (ctrl_reset) begin
         // reset overrides every transfer
         push_s      = 1'b0;
         pop_s       = 1'b0;
         stall_s     = 1'b0;
         sel_valid_s = 1'b0;
      end else begin
         // a full FIFO refuses pushes even when the head pops this cycle
         push_s = ext_req && !full_s;
         case (state_r)
            ST_IDLE: begin
               if (cpu_we) begin
                  sel_valid_s = 1'b1;
                  sel_addr_s  = cpu_waddr;
                  sel_data_s  = cpu_wdata;
               end else begin
                  sel_valid_s = 1'b0;
               end
            end
            ST_WAIT: begin
               if (cpu_we) begin
                  sel_valid_s = 1'b1;
                  sel_addr_s  = cpu_waddr;
                  sel_data_s  = cpu_wdata;
               end else if (!empty_s) begin
                  sel_valid_s = 1'b1;
                  sel_addr_s  = head_addr_s;
                  sel_data_s  = head_data_s;
                  pop_s       = 1'b1;
               end else begin
                  sel_valid_s = 1'b0;
               end
            end
            ST_FORCE: begin
               // CPU write is ignored; it must retry next cycle
               stall_s = 1'b1;
               if (!empty_s) begin
                  sel_valid_s = 1'b1;
                  sel_addr_s  = head_addr_s;
                  sel_data_s  = head_data_s;
                  pop_s       = 1'b1;
               end else begin
                  sel_valid_s = 1'b0;
               end
            end
            default: begin
               sel_valid_s = 1'b0;
            end
         endcase
      end
   end

   assign write_en_s       = sel_valid_s && !is_sink_reg(sel_addr_s);
   assign ctrl_writeEnable = write_en_s;
   assign ctrl_writeReg    = write_en_s ? sel_addr_s : 5'd0;
   assign data_writeReg    = write_en_s ? sel_data_s : 32'd0;
   assign ext_ack          = push_s;
   assign cpu_stall        = stall_s;
   assign ext_count        = count_r;

   // Next occupancy: simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next_s = count_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CNT_ONE;
      end else begin
         count_next_s = count_r;
      end
   end

   // Next arbitration state and starvation counter.
   always_comb begin
      state_next_s    = state_r;
      wait_cnt_next_s = wait_cnt_r;
      case (state_r)
         ST_IDLE: begin
            wait_cnt_next_s = WCNT_ZERO;
            if (push_s) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (count_next_s == CNT_ZERO) begin
               state_next_s    = ST_IDLE;
               wait_cnt_next_s = WCNT_ZERO;
            end else if (pop_s) begin
               state_next_s    = ST_WAIT;
               wait_cnt_next_s = WCNT_ZERO;
            end else if (wait_cnt_r == WCNT_TRIG) begin
               state_next_s    = ST_FORCE;
               wait_cnt_next_s = wait_inc(wait_cnt_r);
            end else begin
               state_next_s    = ST_WAIT;
               wait_cnt_next_s = wait_inc(wait_cnt_r);
            end
         end
         ST_FORCE: begin
            wait_cnt_next_s = WCNT_ZERO;
            if (count_next_s == CNT_ZERO) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         default: begin
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = WCNT_ZERO;
         end
      endcase
   end

   // Control state: FSM, starvation counter, occupancy and pointers.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= WCNT_ZERO;
         count_r    <= CNT_ZERO;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
      end else begin
         state_r    <= state_next_s;
         wait_cnt_r <= wait_cnt_next_s;
         count_r    <= count_next_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // FIFO storage; contents need no reset since occupancy guards reads.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {ext_addr, ext_data};
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.

module tb_rf_write_arbiter;

   localparam int FIFO_DEPTH   = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int CW           = $clog2(FIFO_DEPTH) + 1;

   logic          clock;
   logic          ctrl_reset;
   logic          cpu_we;
   logic [4:0]    cpu_waddr;
   logic [31:0]   cpu_wdata;
   logic          cpu_stall;
   logic          ext_req;
   logic [4:0]    ext_addr;
   logic [31:0]   ext_data;
   logic          ext_ack;
   logic          ctrl_writeEnable;
   logic [4:0]    ctrl_writeReg;
   logic [31:0]   data_writeReg;
   logic [CW-1:0] ext_count;

   int checks = 0;
   int errors = 0;

   // reference model: pending external writes, head wait time, force flag
   logic [36:0] q[$];
   int          waited;
   bit          force_now;
   bit          m_pop;
   bit          m_ack;

   rf_write_arbiter #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .cpu_we           (cpu_we),
      .cpu_waddr        (cpu_waddr),
      .cpu_wdata        (cpu_wdata),
      .cpu_stall        (cpu_stall),
      .ext_req          (ext_req),
      .ext_addr         (ext_addr),
      .ext_data         (ext_data),
      .ext_ack          (ext_ack),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ext_count        (ext_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // drive one cycle's inputs shortly after the rising edge
   task automatic apply(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic er, input logic [4:0] ea,
                        input logic [31:0] ed);
      ctrl_reset = rst;
      cpu_we     = we;
      cpu_waddr  = wa;
      cpu_wdata  = wd;
      ext_req    = er;
      ext_addr   = ea;
      ext_data   = ed;
      #3;
   endtask

   // compare every output against the model for the current inputs
   task automatic model_check(input string tag);
      logic        e_stall;
      logic        sel;
      logic        e_we;
      logic [4:0]  s_addr;
      logic [31:0] s_data;
      e_stall = 1'b0;
      sel     = 1'b0;
      s_addr  = 5'd0;
      s_data  = 32'd0;
      m_pop   = 1'b0;
      m_ack   = 1'b0;
      if (!ctrl_reset) begin
         m_ack = ext_req && (q.size() < FIFO_DEPTH);
         if (force_now) begin
            e_stall = 1'b1;
            sel     = 1'b1;
            s_addr  = q[0][36:32];
            s_data  = q[0][31:0];
            m_pop   = 1'b1;
         end else if (cpu_we) begin
            sel    = 1'b1;
            s_addr = cpu_waddr;
            s_data = cpu_wdata;
         end else if (q.size() > 0) begin
            sel    = 1'b1;
            s_addr = q[0][36:32];
            s_data = q[0][31:0];
            m_pop  = 1'b1;
         end
      end
      e_we = sel && (s_addr != 5'd0) && (s_addr != 5'd29);
      check({tag, "/ack"},   {31'd0, ext_ack}, {31'd0, m_ack});
      check({tag, "/stall"}, {31'd0, cpu_stall}, {31'd0, e_stall});
      check({tag, "/we"},    {31'd0, ctrl_writeEnable}, {31'd0, e_we});
      check({tag, "/reg"},   {27'd0, ctrl_writeReg}, e_we ? {27'd0, s_addr} : 32'd0);
      check({tag, "/data"},  data_writeReg, e_we ? s_data : 32'd0);
      check({tag, "/count"}, {{(32-CW){1'b0}}, ext_count}, 32'(q.size()));
   endtask

   // advance the model across the clock edge, then wait for it
   task automatic tick();
      bit was_empty;
      if (ctrl_reset) begin
         q.delete();
         waited    = 0;
         force_now = 1'b0;
      end else begin
         was_empty = (q.size() == 0);
         if (m_pop) void'(q.pop_front());
         if (m_ack) q.push_back({ext_addr, ext_data});
         if (force_now) begin
            force_now = 1'b0;
            waited    = 0;
         end else if (m_pop || was_empty) begin
            waited = 0;
         end else begin
            if (waited == STARVE_LIMIT - 1) force_now = 1'b1;
            if (waited < STARVE_LIMIT) waited++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic er, input logic [4:0] ea,
                       input logic [31:0] ed, input string tag);
      apply(rst, we, wa, wd, er, ea, ed);
      model_check(tag);
      tick();
   endtask

   initial begin
      logic        r_rst;
      logic        r_we;
      logic        r_er;
      logic [4:0]  r_wa;
      logic [4:0]  r_ea;
      int          thr;
      int          pick;

      waited    = 0;
      force_now = 1'b0;

      // reset: first edge brings DUT out of X, then a checked reset cycle
      apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(posedge clock);
      #1;
      apply(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd6, 32'h0BAD_F00D);
      model_check("reset");
      check("reset_ack0", {31'd0, ext_ack}, 32'd0);
      check("reset_we0", {31'd0, ctrl_writeEnable}, 32'd0);
      check("reset_cnt0", {{(32-CW){1'b0}}, ext_count}, 32'd0);
      tick();

      // CPU write with an empty FIFO goes straight through
      apply(1'b0, 1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0);
      model_check("cpu_direct");
      check("cpu_direct_we", {31'd0, ctrl_writeEnable}, 32'd1);
      check("cpu_direct_reg", {27'd0, ctrl_writeReg}, 32'd5);
      check("cpu_direct_data", data_writeReg, 32'hA5A5_A5A5);
      check("cpu_direct_stall", {31'd0, cpu_stall}, 32'd0);
      tick();

      // four external writes with idle CPU: each drains the next cycle
      for (int k = 0; k < 6; k++) begin
         apply(1'b0, 1'b0, 5'd0, 32'd0, k < 4, 5'(20 + k), 32'hE000_0000 + 32'(k));
         model_check("drain");
         if (k >= 1 && k <= 4) check("drain_reg", {27'd0, ctrl_writeReg}, 32'(19 + k));
         tick();
      end

      // busy CPU: FIFO fills to 4, fifth request refused
      for (int k = 0; k < 10; k++) begin
         apply(1'b0, k < 5, 5'd9, 32'h9999_0000 + 32'(k), k < 6, 5'(20 + k),
               32'hF000_0000 + 32'(k));
         model_check("fill");
         if (k == 4) begin
            check("full_ack", {31'd0, ext_ack}, 32'd0);
            check("full_cnt", {{(32-CW){1'b0}}, ext_count}, 32'd4);
         end
         if (k == 5) begin
            check("full_pop_ack", {31'd0, ext_ack}, 32'd0);
            check("full_pop_reg", {27'd0, ctrl_writeReg}, 32'd20);
         end
         tick();
      end

      // starvation: one entry, CPU always writing -> FORCE on the 9th cycle
      for (int i = 0; i < 11; i++) begin
         apply(1'b0, 1'b1, 5'd3, 32'h1111_0000 + 32'(i), i == 0, 5'd7, 32'hCAFE_0007);
         model_check("starve");
         check("starve_stall", {31'd0, cpu_stall}, (i == 9) ? 32'd1 : 32'd0);
         if (i == 9) begin
            check("force_reg", {27'd0, ctrl_writeReg}, 32'd7);
            check("force_data", data_writeReg, 32'hCAFE_0007);
         end
         if (i == 10) check("force_cnt", {{(32-CW){1'b0}}, ext_count}, 32'd0);
         tick();
      end

      // sink registers r0 and r29 are consumed without a write
      apply(1'b0, 1'b1, 5'd0, 32'h0000_DEAD, 1'b1, 5'd29, 32'h2929_2929);
      model_check("sink0");
      check("sink_cpu_we", {31'd0, ctrl_writeEnable}, 32'd0);
      tick();
      apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      model_check("sink1");
      check("sink_ext_we", {31'd0, ctrl_writeEnable}, 32'd0);
      tick();
      apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      model_check("sink2");
      check("sink_cnt", {{(32-CW){1'b0}}, ext_count}, 32'd0);
      tick();

      // reset while the FIFO holds three entries and is draining
      for (int k = 0; k < 3; k++)
         step(1'b0, 1'b1, 5'd4, 32'h4444_0000, 1'b1, 5'(10 + k), 32'hB000_0000 + 32'(k), "mid_fill");
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hB000_0003, "mid_pushpop");
      apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hB000_0004);
      model_check("mid_reset");
      check("pushpop_cnt", {{(32-CW){1'b0}}, ext_count}, 32'd3);
      tick();
      apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      model_check("post_reset");
      check("post_reset_cnt", {{(32-CW){1'b0}}, ext_count}, 32'd0);
      check("post_reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
      check("post_reset_stall", {31'd0, cpu_stall}, 32'd0);
      tick();

      // random traffic with alternating CPU load
      for (int i = 0; i < 600; i++) begin
         thr   = ((i / 100) % 2 == 1) ? 90 : 35;
         r_rst = ($urandom_range(0, 79) == 0);
         r_we  = ($urandom_range(0, 99) < thr);
         r_er  = ($urandom_range(0, 99) < 45);
         pick  = int'($urandom_range(0, 7));
         r_wa  = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd29 : 5'($urandom_range(1, 31));
         pick  = int'($urandom_range(0, 7));
         r_ea  = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd29 : 5'($urandom_range(1, 31));
         step(r_rst, r_we, r_wa, $urandom, r_er, r_ea, $urandom, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
